// File: rtl/ioc_axi_cfg_master.sv
// ioc_axi_cfg_master
//   Single-beat AXI4 initiator that programs and reads back IOController
//   registers (COMMAND 0x00, DELAY 0x10, EVENT 0x20, POLARITY 0x30).
//   It accepts one request at a time from a simple valid/ready port and
//   reports a one-cycle completion pulse with the AXI response.
//
// Configuration macro: IOC_CFG_MASTER_READ_EN
//   defined   : AR/R read path is built.
//   undefined : arvalid/rready tied 0; a read completes with SLVERR, rdata 0.
//
// Ports
//   s_axi_aclk, s_axi_aresetn     clock, async active-low reset
//   req_valid/ready/write/addr/wdata   request port
//   resp_valid/rdata/code         completion pulse, read data, AXI response
//   busy                          transaction in progress
//   m_axi_aw*, m_axi_w*, m_axi_b*     AXI write channels
//   m_axi_ar*, m_axi_r*           AXI read channels
module ioc_axi_cfg_master #(
  parameter int unsigned  AXI_ADDR_WIDTH   = 6,
  parameter int unsigned  AXI_DATA_WIDTH   = 128,
  parameter logic [15:0]  AXI_ID           = 16'h0,
  localparam int unsigned AXI_STROBE_WIDTH = AXI_DATA_WIDTH / 8
) (
  input  logic                        s_axi_aclk,
  input  logic                        s_axi_aresetn,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [AXI_ADDR_WIDTH-1:0]   req_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   req_wdata,
  output logic                        resp_valid,
  output logic [AXI_DATA_WIDTH-1:0]   resp_rdata,
  output logic [1:0]                  resp_code,
  output logic                        busy,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [15:0]                 m_axi_awid,
  output logic [1:0]                  m_axi_awburst,
  output logic [2:0]                  m_axi_awsize,
  output logic [7:0]                  m_axi_awlen,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_STROBE_WIDTH-1:0] m_axi_wstrb,
  output logic                        m_axi_wlast,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [15:0]                 m_axi_bid,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [15:0]                 m_axi_arid,
  output logic [1:0]                  m_axi_arburst,
  output logic [2:0]                  m_axi_arsize,
  output logic [7:0]                  m_axi_arlen,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic [15:0]                 m_axi_rid,
  input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rlast,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready
);

  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    DONE    = 3'd5
  } state_e;

  state_e                      state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                        awvalid_q, awvalid_d;
  logic                        wvalid_q, wvalid_d;
  logic                        bready_q, bready_d;
  logic                        aw_done_q, aw_done_d;
  logic                        w_done_q, w_done_d;
  // Collected response, published to resp_* together with resp_valid
  logic [1:0]                  rsp_code_q, rsp_code_d;
  logic [AXI_DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [1:0]                  resp_code_q, resp_code_d;
  logic [AXI_DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
  logic                        resp_valid_q, resp_valid_d;
  logic                        busy_q, busy_d;
  logic                        req_ready_q, req_ready_d;

  logic req_hs, aw_hs, w_hs, b_hs;

  assign req_hs = req_valid & req_ready_q;
  assign aw_hs  = awvalid_q & m_axi_awready;
  assign w_hs   = wvalid_q & m_axi_wready;
  assign b_hs   = m_axi_bvalid & bready_q;

`ifdef IOC_CFG_MASTER_READ_EN
  logic arvalid_q, arvalid_d;
  logic rready_q, rready_d;
  logic beat_seen_q, beat_seen_d;
  logic ar_hs, r_hs;

  assign ar_hs = arvalid_q & m_axi_arready;
  assign r_hs  = m_axi_rvalid & rready_q;
`else
  logic unused_rd_inputs;
  assign unused_rd_inputs = ^{m_axi_arready, m_axi_rid, m_axi_rdata,
                              m_axi_rresp, m_axi_rlast, m_axi_rvalid};
`endif

  // State and registered outputs
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      rsp_code_q   <= '0;
      rsp_data_q   <= '0;
      resp_code_q  <= '0;
      resp_rdata_q <= '0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      req_ready_q  <= 1'b0;
`ifdef IOC_CFG_MASTER_READ_EN
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      beat_seen_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      rsp_code_q   <= rsp_code_d;
      rsp_data_q   <= rsp_data_d;
      resp_code_q  <= resp_code_d;
      resp_rdata_q <= resp_rdata_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
      req_ready_q  <= req_ready_d;
`ifdef IOC_CFG_MASTER_READ_EN
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      beat_seen_q  <= beat_seen_d;
`endif
    end
  end

  // Next state and next values of registered outputs
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    rsp_code_d   = rsp_code_q;
    rsp_data_d   = rsp_data_q;
    resp_code_d  = resp_code_q;
    resp_rdata_d = resp_rdata_q;
    resp_valid_d = 1'b0;
`ifdef IOC_CFG_MASTER_READ_EN
    beat_seen_d  = beat_seen_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (req_hs) begin
          addr_d = req_addr;
          if (req_write) begin
            wdata_d   = req_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = WR_AW_W;
          end else begin
`ifdef IOC_CFG_MASTER_READ_EN
            beat_seen_d = 1'b0;
            state_d     = RD_AR;
`else
            rsp_code_d  = RESP_SLVERR;
            rsp_data_d  = '0;
            state_d     = DONE;
`endif
          end
        end
      end

      // AW and W complete independently; each valid drops after its own handshake
      WR_AW_W: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          state_d = WR_B;
        end
      end

      WR_B: begin
        if (b_hs) begin
          rsp_code_d = (m_axi_bid != AXI_ID) ? RESP_SLVERR : m_axi_bresp;
          rsp_data_d = '0;
          state_d    = DONE;
        end
      end

`ifdef IOC_CFG_MASTER_READ_EN
      RD_AR: begin
        if (ar_hs) begin
          state_d = RD_R;
        end
      end

      // Keep only the first beat; a multi-beat answer is drained and flagged
      RD_R: begin
        if (r_hs) begin
          if (!beat_seen_q) begin
            rsp_data_d = m_axi_rdata;
            rsp_code_d = (m_axi_rid != AXI_ID) ? RESP_SLVERR : m_axi_rresp;
          end
          if (!m_axi_rlast) begin
            rsp_code_d = RESP_SLVERR;
          end
          beat_seen_d = 1'b1;
          if (m_axi_rlast) begin
            state_d = DONE;
          end
        end
      end
`endif

      DONE: begin
        resp_code_d  = rsp_code_q;
        resp_rdata_d = rsp_data_q;
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    bready_d    = (state_d == WR_B);
    busy_d      = (state_d != IDLE);
    // Hold off new requests during the resp_valid cycle
    req_ready_d = (state_d == IDLE) && (state_q != DONE);
`ifdef IOC_CFG_MASTER_READ_EN
    arvalid_d   = (state_d == RD_AR);
    rready_d    = (state_d == RD_R);
`endif
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_code     = resp_code_q;
  assign busy          = busy_q;

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awid    = AXI_ID;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awsize  = 3'b100;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = {AXI_STROBE_WIDTH{1'b1}};
  assign m_axi_wlast   = wvalid_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;

  assign m_axi_araddr  = addr_q;
  assign m_axi_arid    = AXI_ID;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arsize  = 3'b100;
  assign m_axi_arlen   = 8'd0;
`ifdef IOC_CFG_MASTER_READ_EN
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
`else
  assign m_axi_arvalid = 1'b0;
  assign m_axi_rready  = 1'b0;
`endif

endmodule
